// File: rtl/periph_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : periph_irq_pkg
// Purpose  : Shared register map, FSM state encoding and helpers for the
//            peripheral interrupt arbiter.
// Revision : 1.0
// ============================================================================
package periph_irq_pkg;

    localparam logic [31:0] REG_MASK    = 32'h0000_0000;
    localparam logic [31:0] REG_PENDING = 32'h0000_0004;
    localparam logic [31:0] REG_ACTIVE  = 32'h0000_0008;
    localparam logic [31:0] REG_MODE    = 32'h0000_000C;

    localparam logic [31:0] CAUSE_BASE_DEFAULT = 32'h8000_0010;

    // Grant index width covers the full legal source range (up to 16).
    localparam int ID_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RETURN = 2'd2
    } state_t;

    // Successor of a source index, wrapping back to 0 after the last source.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int n);
        if ({28'd0, v} >= 32'(n - 1)) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_picker
// Purpose  : Combinational picker; fixed (lowest index) or round-robin from ptr.
// Revision : 1.0
// ============================================================================
module rr_priority_picker
    import periph_irq_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             mode,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    localparam logic [ID_W:0] N_EXT = N_SRC[ID_W:0];

    logic [ID_W-1:0]  start;
    logic [N_SRC-1:0] rotated;
    logic [ID_W-1:0]  offset;
    logic [ID_W:0]    sum;
    logic [ID_W:0]    diff;

    assign start = mode ? ptr : '0;

    // Rotating a doubled copy puts the search start at bit 0, so the lowest
    // set bit is the first requester at or after start.
    assign rotated = N_SRC'({req, req} >> start);

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = ID_W'(i);
            end
        end
    end

    assign sum  = {1'b0, start} + {1'b0, offset};
    assign diff = sum - N_EXT;
    assign idx  = (sum >= N_EXT) ? diff[ID_W-1:0] : sum[ID_W-1:0];

endmodule
`default_nettype wire

// File: rtl/periph_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : periph_irq_arbiter
// Purpose  : Shares the core interrupt line among N_SRC peripheral sources with
//            a bus-mapped mask/mode/status register file.
// Revision : 1.0
// ============================================================================
module periph_irq_arbiter
    import periph_irq_pkg::*;
#(
    parameter int          N_SRC      = 4,
    parameter logic [31:0] CAUSE_BASE = CAUSE_BASE_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [31:0]      addr_i,
    input  logic             req_i,
    input  logic             write_enable_i,
    input  logic [31:0]      write_data_i,
    output logic [31:0]      read_data_o,
    input  logic [N_SRC-1:0] irq_req_i,
    output logic [N_SRC-1:0] irq_ret_o,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    input  logic             mret_i
);

    state_t           state;
    state_t           state_nxt;
    logic [N_SRC-1:0] mask;
    logic             mode;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  rr_ptr_nxt;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  grant_id_nxt;
    logic             irq_nxt;
    logic [31:0]      cause_nxt;
    logic [N_SRC-1:0] ret_nxt;
    logic [N_SRC-1:0] grant_onehot;
    logic [N_SRC-1:0] cand;
    logic             found;
    logic [ID_W-1:0]  winner;
    logic             busy;
    logic             bus_wr;
    logic             bus_rd;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign cand   = irq_req_i & mask;
    assign busy   = (state != IDLE);
    assign bus_wr = req_i & write_enable_i;
    assign bus_rd = req_i & ~write_enable_i;

    assign unused_wdata = ^write_data_i;

    rr_priority_picker #(
        .N_SRC (N_SRC)
    ) u_picker (
        .req   (cand),
        .ptr   (rr_ptr),
        .mode  (mode),
        .found (found),
        .idx   (winner)
    );

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            grant_onehot[i] = (grant_id == ID_W'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        irq_nxt      = irq_o;
        cause_nxt    = irq_cause_o;
        ret_nxt      = '0;
        grant_id_nxt = grant_id;
        rr_ptr_nxt   = rr_ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_id_nxt = winner;
                    irq_nxt      = 1'b1;
                    cause_nxt    = CAUSE_BASE | 32'(winner);
                    rr_ptr_nxt   = wrap_inc(winner, N_SRC);
                    state_nxt    = ACTIVE;
                end
            end
            // The core owns the grant: request drops or mask changes do not revoke it.
            ACTIVE: begin
                if (mret_i) begin
                    irq_nxt   = 1'b0;
                    cause_nxt = '0;
                    ret_nxt   = grant_onehot;
                    state_nxt = RETURN;
                end
            end
            RETURN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_o       <= 1'b0;
            irq_cause_o <= '0;
            irq_ret_o   <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
        end else begin
            irq_o       <= irq_nxt;
            irq_cause_o <= cause_nxt;
            irq_ret_o   <= ret_nxt;
            grant_id    <= grant_id_nxt;
            rr_ptr      <= rr_ptr_nxt;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            REG_MASK:    rd_mux = 32'(mask);
            REG_PENDING: rd_mux = 32'(cand);
            REG_ACTIVE:  rd_mux = {busy, 27'd0, grant_id};
            REG_MODE:    rd_mux = {31'd0, mode};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask        <= '0;
            mode        <= 1'b0;
            read_data_o <= '0;
        end else begin
            if (bus_wr && addr_i == REG_MASK) begin
                mask <= write_data_i[N_SRC-1:0];
            end
            if (bus_wr && addr_i == REG_MODE) begin
                mode <= write_data_i[0];
            end
            if (bus_rd) begin
                read_data_o <= rd_mux;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_periph_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_periph_irq_arbiter
// Purpose  : Self-checking scoreboard bench for periph_irq_arbiter (N_SRC=4).
// Revision : 1.0
// ============================================================================
module tb_periph_irq_arbiter;

    localparam int          N     = 4;
    localparam logic [31:0] CBASE = 32'h8000_0010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   addr = '0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic [N-1:0]  irq_req = '0;
    logic [N-1:0]  irq_ret;
    logic          irq;
    logic [31:0]   cause;
    logic          mret = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    periph_irq_arbiter #(
        .N_SRC      (N),
        .CAUSE_BASE (CBASE)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .addr_i         (addr),
        .req_i          (req),
        .write_enable_i (we),
        .write_data_i   (wdata),
        .read_data_o    (rdata),
        .irq_req_i      (irq_req),
        .irq_ret_o      (irq_ret),
        .irq_o          (irq),
        .irq_cause_o    (cause),
        .mret_i         (mret)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 1'b0;
        we      = 1'b0;
        mret    = 1'b0;
        irq_req = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        req   = 1'b1;
        we    = 1'b1;
        tick();
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        addr = a;
        req  = 1'b1;
        we   = 1'b0;
        tick();
        req = 1'b0;
        check(tag, rdata, exp_q.pop_front());
    endtask

    task automatic wait_grant(input string tag, input int id);
        int n;
        exp_q.push_back(CBASE | 32'(id));
        n = 0;
        while (!irq && n < 20) begin
            tick();
            n++;
        end
        if (!irq) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end else begin
            check({tag, "_cause"}, cause, exp_q.pop_front());
        end
    endtask

    task automatic do_return(input string tag, input int id);
        exp_q.push_back(32'(1 << id));
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check({tag, "_ret"}, 32'(irq_ret), exp_q.pop_front());
        check({tag, "_irq_low"}, 32'(irq), 32'd0);
        tick();
        check({tag, "_ret_clear"}, 32'(irq_ret), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state with everything masked
        irq_req = 4'b1111;
        do_reset();
        irq_req = 4'b1111;
        tick();
        tick();
        check("masked_irq", 32'(irq), 32'd0);
        check("reset_cause", cause, 32'd0);
        bus_read("pending_masked", 32'h4, 32'd0);
        bus_read("active_reset", 32'h8, 32'd0);
        bus_read("mask_reset", 32'h0, 32'd0);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        check("mret_idle_no_ret", 32'(irq_ret), 32'd0);

        // Unmapped access and MODE readback
        bus_write(32'h10, 32'hFFFF_FFFF);
        bus_read("unmapped", 32'h10, 32'd0);
        bus_write(32'hC, 32'h1);
        bus_read("mode_rb", 32'hC, 32'd1);
        bus_write(32'hC, 32'h0);

        // MASK write in the same cycle as a new request uses the old mask
        irq_req = 4'b0100;
        bus_write(32'h0, 32'h4);
        check("old_mask_used", 32'(irq), 32'd0);
        tick();
        check("latency_irq", 32'(irq), 32'd1);
        wait_grant("src2", 2);
        bus_read("pending_src2", 32'h4, 32'h4);
        bus_read("active_src2", 32'h8, 32'h8000_0002);
        do_return("src2", 2);
        irq_req = '0;
        tick();
        check("idle_after_ret", 32'(irq), 32'd0);

        // Fixed priority: lowest index wins, repeatedly
        bus_write(32'h0, 32'hF);
        irq_req = 4'b1010;
        wait_grant("fixed_a", 1);
        do_return("fixed_a", 1);
        wait_grant("fixed_b", 1);
        do_return("fixed_b", 1);
        irq_req = '0;
        tick();

        // Round-robin rotation with all sources held
        do_reset();
        bus_write(32'h0, 32'hF);
        bus_write(32'hC, 32'h1);
        irq_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant($sformatf("rr%0d", k), k % N);
            do_return($sformatf("rr%0d", k), k % N);
        end
        irq_req = '0;
        tick();

        // Grant is held through request drop and mask clear; mret in RETURN ignored
        irq_req = 4'b1000;
        wait_grant("hold3", 3);
        irq_req = '0;
        bus_write(32'h0, 32'h0);
        tick();
        tick();
        check("hold3_irq", 32'(irq), 32'd1);
        check("hold3_cause", cause, 32'h8000_0013);
        mret = 1'b1;
        tick();
        check("hold3_ret", 32'(irq_ret), 32'h8);
        tick();
        mret = 1'b0;
        check("mret_in_return", 32'(irq_ret), 32'd0);
        tick();
        check("hold3_idle", 32'(irq), 32'd0);

        // Asynchronous reset while ACTIVE
        bus_write(32'h0, 32'hF);
        irq_req = 4'b0001;
        wait_grant("rst_src0", 0);
        #2;
        rst_n = 1'b0;
        mret  = 1'b1;
        #1;
        check("async_rst_irq", 32'(irq), 32'd0);
        check("async_rst_cause", cause, 32'd0);
        tick();
        check("async_rst_no_ret", 32'(irq_ret), 32'd0);
        mret    = 1'b0;
        irq_req = '0;
        rst_n   = 1'b1;
        bus_read("mask_after_rst", 32'h0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
